// File: rtl/qr_loop_ctrl_if.sv
// Operation handshake between the QR loop sequencer and the projection/normalisation datapath.
// master = sequencer (offers operations), slave = datapath (accepts them).
interface qr_loop_ctrl_if #(
  parameter int CW = 4
);
  logic          op_valid;
  logic          op_ready;
  logic          op_norm;
  logic [CW-1:0] op_k;
  logic [CW-1:0] op_j;

  modport master (output op_valid, op_norm, op_k, op_j, input op_ready);
  modport slave  (input op_valid, op_norm, op_k, op_j, output op_ready);
endinterface

// File: rtl/qr_loop_ctrl.sv
// Gram-Schmidt QR loop sequencer: walks (k, j) via external counters and issues PROJ/NORM ops.
// Optional feature macro QR_LOOP_PERF_EN adds a saturating 16-bit backpressure stall counter.
module qr_loop_ctrl #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] oc_cnt,
  input  logic [CW-1:0] ic_cnt,
  output logic          oc_clr,
  output logic          oc_en,
  output logic          ic_clr,
  output logic          ic_en,
  qr_loop_ctrl_if.master op,
  output logic          busy,
  output logic          done
`ifdef QR_LOOP_PERF_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_K = CW'(N - 1);

  state_t state_reg;
  state_t state_next;
  logic   is_norm;
  logic   is_last_k;

  assign is_norm   = (ic_cnt == oc_cnt);
  assign is_last_k = (oc_cnt == LAST_K);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    oc_clr      = 1'b0;
    oc_en       = 1'b0;
    ic_clr      = 1'b0;
    ic_en       = 1'b0;
    op.op_valid = 1'b0;
    op.op_norm  = 1'b0;
    op.op_k     = '0;
    op.op_j     = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLR;
        end
      end
      CLR: begin
        oc_clr     = 1'b1;
        ic_clr     = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        op.op_valid = 1'b1;
        op.op_norm  = is_norm;
        op.op_k     = oc_cnt;
        op.op_j     = ic_cnt;
        // Strobes fire only on the handshake so a stalled offer keeps its indices.
        if (op.op_ready) begin
          if (!is_norm) begin
            ic_en = 1'b1;
          end else if (!is_last_k) begin
            oc_en  = 1'b1;
            ic_clr = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

`ifdef QR_LOOP_PERF_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == CLR) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == ISSUE) && !op.op_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_qr_loop_ctrl.sv
// Directed bench for qr_loop_ctrl: three instances (N=4, N=1, N=16) each with a modelled counter pair.
// Checks op order, strobes per handshake, stall behaviour, latency, busy/done and async reset.
module tb_qr_loop_ctrl;

  localparam int NS [3] = '{4, 1, 16};

  logic clk;
  logic reset;
  logic [2:0] start;
  logic [2:0] rdy;
  logic [2:0] oc_clr, oc_en, ic_clr, ic_en;
  logic [2:0] vld, norm, busy, done;
  logic [2:0][3:0] opk, opj;
`ifdef QR_LOOP_PERF_EN
  logic [2:0][15:0] stall_c;
`endif

  int n_vec = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    qr_loop_ctrl_if #(.CW(4)) opb ();
    logic [3:0] oc_r = '0;
    logic [3:0] ic_r = '0;

    // Counter model: clear has priority over enable.
    always_ff @(posedge clk) begin
      if (oc_clr[gi])     oc_r <= '0;
      else if (oc_en[gi]) oc_r <= oc_r + 4'd1;
      if (ic_clr[gi])     ic_r <= '0;
      else if (ic_en[gi]) ic_r <= ic_r + 4'd1;
    end

    qr_loop_ctrl #(.N(NS[gi]), .CW(4)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start[gi]),
      .oc_cnt (oc_r),
      .ic_cnt (ic_r),
      .oc_clr (oc_clr[gi]),
      .oc_en  (oc_en[gi]),
      .ic_clr (ic_clr[gi]),
      .ic_en  (ic_en[gi]),
      .op     (opb),
      .busy   (busy[gi]),
      .done   (done[gi])
`ifdef QR_LOOP_PERF_EN
      ,
      .stall_cnt (stall_c[gi])
`endif
    );

    assign opb.op_ready = rdy[gi];
    assign vld[gi]      = opb.op_valid;
    assign norm[gi]     = opb.op_norm;
    assign opk[gi]      = opb.op_k;
    assign opj[gi]      = opb.op_j;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] out_word(input int idx);
    return {busy[idx], done[idx], vld[idx], norm[idx],
            oc_clr[idx], oc_en[idx], ic_clr[idx], ic_en[idx], opk[idx], opj[idx]};
  endfunction

  // mode 0: ready high; 1: 3-cycle stall on P(2,1); 2: random ready; 3: start pulse at k=2.
  // exp_cycles 0 means "derive from observed stalls".
  task automatic run_seq(input int idx, input int n, input int mode, input int exp_cycles);
    logic [8:0] exp_q [$];
    logic [9:0] exp_op;
    logic [3:0] exp_strb;
    int cyc, got, stalls, busy_cnt, stall_seen, expc;
    logic pulsed, fin;

    exp_q = {};
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < k; j++) exp_q.push_back({1'b0, 4'(k), 4'(j)});
      exp_q.push_back({1'b1, 4'(k), 4'(k)});
    end

    start[idx] = 1'b1;
    @(posedge clk); #1;
    start[idx] = 1'b0;
    cyc = 1; got = 0; stalls = 0; busy_cnt = 0; stall_seen = 0; pulsed = 1'b0; fin = 1'b0;
    check("clr_strobes", {oc_clr[idx], oc_en[idx], ic_clr[idx], ic_en[idx]}, 4'b1010);

    while (!fin && cyc < 2000) begin
      start[idx] = 1'b0;
      case (mode)
        1: begin
          rdy[idx] = !(vld[idx] && !norm[idx] && opk[idx] == 4'd2 && opj[idx] == 4'd1 && stall_seen < 3);
          if (!rdy[idx]) stall_seen++;
        end
        2: rdy[idx] = 1'($urandom_range(0, 1));
        3: begin
          if (vld[idx] && opk[idx] == 4'd2 && !pulsed) begin
            start[idx] = 1'b1;
            pulsed     = 1'b1;
          end
          rdy[idx] = 1'b1;
        end
        default: rdy[idx] = 1'b1;
      endcase
      @(negedge clk);
      if (busy[idx]) busy_cnt++;
      if (done[idx]) begin
        fin  = 1'b1;
        expc = (exp_cycles != 0) ? exp_cycles : (n * (n + 1) / 2 + 2 + stalls);
        check("op_count", got, exp_q.size());
        check("latency", cyc, expc);
      end else if (vld[idx]) begin
        exp_op   = (got < exp_q.size()) ? {1'b0, exp_q[got]} : 10'h3FF;
        exp_strb = !exp_op[8] ? 4'b0001 : ((exp_op[7:4] < 4'(n - 1)) ? 4'b0110 : 4'b0000);
        check("offer", {1'b0, norm[idx], opk[idx], opj[idx]}, exp_op);
        if (rdy[idx]) begin
          check("hs_strobes", {oc_clr[idx], oc_en[idx], ic_clr[idx], ic_en[idx]}, exp_strb);
          got++;
        end else begin
          stalls++;
          check("stall_strobes", {oc_clr[idx], oc_en[idx], ic_clr[idx], ic_en[idx]}, 4'b0000);
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end

    check("no_timeout", fin, 1'b1);
    check("busy_cycles", busy_cnt, cyc);
    if (mode == 1) check("stall_total", stalls, 3);
`ifdef QR_LOOP_PERF_EN
    if (mode == 1) check("stall_cnt", stall_c[idx], 16'd3);
`endif
    rdy[idx]   = 1'b0;
    start[idx] = 1'b0;
    @(posedge clk); #1;
    check("post_done", {done[idx], busy[idx]}, 2'b00);
    $display("run inst=%0d N=%0d mode=%0d ops=%0d stalls=%0d cycles=%0d", idx, n, mode, got, stalls, cyc);
  endtask

  initial begin
    int i;
    reset = 1'b0;
    start = '0;
    rdy   = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int idx = 0; idx < 3; idx++) check("reset_out", out_word(idx), 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    check("idle_out", out_word(0), 16'h0000);
    rdy[0] = 1'b0;

    run_seq(0, 4, 0, 12);
    run_seq(0, 4, 1, 15);
    run_seq(1, 1, 0, 3);
    run_seq(0, 4, 3, 12);

    // Asynchronous reset in the middle of k=2, then a clean rerun.
    rdy[0]   = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    i = 0;
    while (!(vld[0] && opk[0] == 4'd2) && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("reach_k2", {vld[0], opk[0]}, {1'b1, 4'd2});
    #2 reset = 1'b0;
    #1 check("async_reset_out", out_word(0), 16'h0000);
    @(negedge clk);
    #3 reset = 1'b1;
    rdy[0] = 1'b0;
    @(posedge clk); #1;
    $display("reset applied mid-run at k=2");
    run_seq(0, 4, 0, 12);

    run_seq(2, 16, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qr_loop_ctrl.md
# qr_loop_ctrl

Loop sequencer for the Gram-Schmidt QR engine. It drives the outer-column (k) and inner-column (j) index counters through clear and enable strobes, and reads their counts back. From those counts it issues one operation per column pair to the projection/normalisation datapath over a valid/ready handshake. It sits between the top-level start/done control and the two column counters.

## Interface
- `N`, default 4: matrix dimension (column count). Legal range 1..16.
- `CW`, default 4: width of the counter count buses. Must satisfy 2^CW ≥ N.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `start` in 1: one-cycle request to begin a decomposition. Sampled only in IDLE.
- `oc_cnt` in CW: current outer-column count (k), read from the outer counter.
- `ic_cnt` in CW: current inner-column count (j), read from the inner counter.
- `oc_clr` out 1: synchronous clear strobe to the outer counter.
- `oc_en` out 1: increment enable to the outer counter.
- `ic_clr` out 1: synchronous clear strobe to the inner counter.
- `ic_en` out 1: increment enable to the inner counter.
- `op_valid` out 1: an operation is being offered to the datapath.
- `op_ready` in 1: the datapath accepts the offered operation.
- `op_norm` out 1: operation type. 0 = PROJ (project column k onto q_j); 1 = NORM (normalise column k).
- `op_k` out CW: k index of the operation (equal to `oc_cnt`).
- `op_j` out CW: j index of the operation (equal to `ic_cnt`).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the decomposition completes.

## Operation
- FSM states: IDLE, CLR, ISSUE, DONE.
- IDLE:
  - All strobes are low.
  - `start`=1 moves the FSM to CLR.
- CLR (1 cycle):
  - `oc_clr` = `ic_clr` = 1.
  - Next state is ISSUE.
- ISSUE:
  - `op_valid` = 1.
  - `op_norm` = (`ic_cnt` == `oc_cnt`).
  - `op_k` = `oc_cnt`, `op_j` = `ic_cnt`.
- Handshake event hs = `op_valid` & `op_ready`. Actions on hs:
  - PROJ: `ic_en` = 1.
  - NORM with `oc_cnt` < N-1: `oc_en` = 1 and `ic_clr` = 1. Remain in ISSUE.
  - NORM with `oc_cnt` == N-1: go to DONE. No strobes.
- DONE (1 cycle): `done` = 1, then go to IDLE.
- Operation order: for k = 0..N-1, issue PROJ(k,j) for j = 0..k-1, then NORM(k). Total N(N+1)/2 operations.
- The counters give clear priority over enable, so `ic_clr` and `ic_en` are never asserted in the same cycle.
- Strobes and `op_*` are combinational from state, counts and `op_ready`. `done` and `busy` are decoded from the state register.
- Reset values:
  - State = IDLE.
  - All outputs = 0. `op_k`/`op_j` read 0 because they are gated to 0 outside ISSUE.

## Timing
- `start` is sampled at edge 0.
- CLR is active in cycle 1.
- The first `op_valid` appears in cycle 2 with k=0, j=0.
- With `op_ready` held high, throughput is one operation per cycle. Counters update on the same edge as hs, so the next operation's indices are valid in the following cycle.
- `done` pulses in the cycle after the final NORM handshake.
- Total latency from `start` to `done` with no stalls: N(N+1)/2 + 2 cycles.
- While `op_valid` & !`op_ready`: `op_norm`, `op_k`, `op_j` hold stable and no strobe is asserted.
- `start` while `busy`: ignored, with no effect on sequence or counts.
- `start` during the DONE cycle: ignored.
- N = 1: a single NORM(0,0), then DONE.
- Asynchronous reset mid-run:
  - The FSM goes to IDLE immediately and all outputs drop.
  - Stale counter values are tolerated because the next `start` passes through CLR.

## Configuration
- `QR_LOOP_PERF_EN` defined:
  - Adds output `stall_cnt` (16 bits).
  - Counts cycles with `op_valid` & !`op_ready`.
  - Cleared in CLR and by reset; saturates at 16'hFFFF.
  - Holds its value after `done` until the next `start`.
- Not defined: the port and its logic are absent. Everything else behaves identically.

## Test plan
- **Full run, no stalls.** N=4, `op_ready`=1, pulse `start` → order N(0,0) P(1,0) N(1,1) P(2,0) P(2,1) N(2,2) P(3,0) P(3,1) P(3,2) N(3,3). Exactly 10 hs. `done` in cycle 12 after `start`. `busy` high cycles 1..12.
- **Backpressure.** `op_ready` low for 3 cycles while P(2,1) is offered → offer held stable, no strobes, run stretches by 3 cycles. With `QR_LOOP_PERF_EN`, `stall_cnt` = 3 at `done`.
- **Minimum size.** N=1 → CLR, one NORM(0,0), `done`. 3 cycles total from `start`.
- **Start while busy.** `start` pulsed during k=2 → sequence and final count unchanged, single `done`.
- **Reset mid-run.** `reset` low during ISSUE at k=2 → all outputs 0 asynchronously. A subsequent `start` reproduces the full N=4 sequence from (0,0).
- **Full dimension.** N=16, `op_ready` random 50% → 136 hs in the specified order. `oc_cnt` never exceeds 15.
